// File: rtl/inst_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words,
// drives the memory write port, and stalls fetch until the program image is loaded.
module inst_mem_loader #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_byte,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_waddr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [31:0]          fetch_addr,
  output logic [31:0]          mem_raddr,
  output logic                 fetch_stall,
  output logic                 fetch_err,
  output logic                 load_done,
  output logic                 overflow,
  output logic [31:0]          words_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;

  state_t               r_state;
  logic                 r_ld_ready;
  logic                 r_mem_we;
  logic [31:0]          r_mem_waddr;
  logic [DATA_SIZE-1:0] r_mem_wdata;
  logic                 r_fetch_stall;
  logic                 r_load_done;
  logic                 r_overflow;
  logic [31:0]          r_ptr;
  logic [1:0]           r_byte_cnt;
  logic [DATA_SIZE-1:0] r_word;

  logic [DATA_SIZE-1:0] w_byte_placed;
  logic [DATA_SIZE-1:0] w_packed;
  logic                 w_word_end;
  logic                 w_mem_full;

  // Byte k of a word lands in bits [31-8k:24-8k]; the incoming byte is merged
  // with the partial word so the write carries it without an extra cycle.
  assign w_byte_placed = {ld_byte, 24'd0} >> {r_byte_cnt, 3'b000};
  assign w_packed      = r_word | w_byte_placed;
  assign w_word_end    = (r_byte_cnt == 2'd3) || ld_last;
  assign w_mem_full    = (r_ptr == 32'(MEM_SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ld_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_waddr   <= '0;
      r_mem_wdata   <= '0;
      r_fetch_stall <= 1'b1;
      r_load_done   <= 1'b0;
      r_overflow    <= 1'b0;
      r_ptr         <= '0;
      r_byte_cnt    <= '0;
      r_word        <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (ld_start) begin
            r_state       <= S_LOAD;
            r_ld_ready    <= 1'b1;
            r_fetch_stall <= 1'b1;
            r_load_done   <= 1'b0;
            r_overflow    <= 1'b0;
            r_ptr         <= '0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
          end
        end
        S_LOAD: begin
          if (ld_valid && r_ld_ready) begin
            if (w_mem_full) begin
              r_overflow <= 1'b1;
            end else if (w_word_end) begin
              r_mem_we    <= 1'b1;
              r_mem_waddr <= r_ptr;
              r_mem_wdata <= w_packed;
              r_ptr       <= r_ptr + 32'd1;
            end
            r_byte_cnt <= w_word_end ? 2'd0 : r_byte_cnt + 2'd1;
            r_word     <= w_word_end ? '0 : w_packed;
            if (ld_last) begin
              r_state    <= S_DONE;
              r_ld_ready <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state       <= S_RUN;
          r_fetch_stall <= 1'b0;
          r_load_done   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready     = r_ld_ready;
  assign mem_we       = r_mem_we;
  assign mem_waddr    = r_mem_waddr;
  assign mem_wdata    = r_mem_wdata;
  assign fetch_stall  = r_fetch_stall;
  assign load_done    = r_load_done;
  assign overflow     = r_overflow;
  assign words_loaded = r_ptr;

  assign mem_raddr = {2'b00, fetch_addr[31:2]};
  assign fetch_err = r_load_done &&
                     ((fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_addr[31:2]} >= r_ptr));

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: stimulus queues expected writes,
// a negedge monitor pops and compares whenever the DUT strobes mem_we.
module tb_inst_mem_loader;

  localparam int MEM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready, mem_we;
  logic [31:0] mem_waddr, mem_wdata, fetch_addr, mem_raddr, words_loaded;
  logic        fetch_stall, fetch_err, load_done, overflow;

  inst_mem_loader #(.DATA_SIZE(32), .MEM_SIZE(MEM)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .fetch_addr(fetch_addr), .mem_raddr(mem_raddr), .fetch_stall(fetch_stall),
    .fetch_err(fetch_err), .load_done(load_done), .overflow(overflow),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] load_bytes[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=(0x%08h,0x%08h) required=none", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_waddr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_cycle", cyc, e.cyc);
        $display("write addr=%0d data=0x%08h", mem_waddr, mem_wdata);
      end
    end
  end

  // Reference: bytes are packed big-endian into words; words beyond MEM are dropped.
  task automatic do_load(input bit from_run);
    int          n;
    int          nwords;
    int          exp_words;
    bit          exp_ovf;
    logic [31:0] w;
    n         = load_bytes.size();
    nwords    = (n + 3) / 4;
    exp_words = (nwords < MEM) ? nwords : MEM;
    exp_ovf   = (n > 4 * MEM);
    fetch_addr = 32'd1;
    check("pre_start_ready", {31'd0, ld_ready}, 32'd0);
    if (from_run) check("run_stall_before_start", {31'd0, fetch_stall}, 32'd0);
    ld_start = 1'b1;
    ld_valid = 1'($urandom_range(0, 1));
    ld_byte  = 8'hFF;
    ld_last  = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("load_ready", {31'd0, ld_ready}, 32'd1);
    check("load_stall", {31'd0, fetch_stall}, 32'd1);
    check("load_clr_words", words_loaded, 32'd0);
    check("load_clr_ovf", {31'd0, overflow}, 32'd0);
    w = '0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = load_bytes[i];
      ld_last  = (i == n - 1);
      w[31 - 8 * (i % 4) -: 8] = load_bytes[i];
      if ((i % 4 == 3) || (i == n - 1)) begin
        if (i / 4 < MEM) exp_q.push_back('{addr: 32'(i / 4), data: w, cyc: cyc + 1});
        w = '0;
      end
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
    check("done_stall", {31'd0, fetch_stall}, 32'd1);
    check("done_ready", {31'd0, ld_ready}, 32'd0);
    check("done_load_done", {31'd0, load_done}, 32'd0);
    check("done_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    check("run_stall", {31'd0, fetch_stall}, 32'd0);
    check("run_load_done", {31'd0, load_done}, 32'd1);
    check("run_words", words_loaded, 32'(exp_words));
    check("run_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
    check("run_fetch_misaligned", {31'd0, fetch_err}, 32'd1);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("load bytes=%0d words=%0d overflow=%0d", n, exp_words, exp_ovf);
  endtask

  task automatic fetch_chk(input logic [31:0] a, input int words);
    bit err;
    fetch_addr = a;
    #1;
    err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(words));
    check("raddr", mem_raddr, a >> 2);
    check("fetch_err", {31'd0, fetch_err}, {31'd0, err});
    $display("fetch addr=0x%08h raddr=%0d err=%0d", a, mem_raddr, fetch_err);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
    fetch_addr = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_waddr", mem_waddr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_stall", {31'd0, fetch_stall}, 32'd1);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_words", words_loaded, 32'd0);
    check("rst_raddr", mem_raddr, 32'd0);
    rst = 1'b0;
    // ld_valid alone in IDLE must not start anything
    ld_valid = 1'b1; ld_byte = 8'h55;
    @(negedge clk);
    ld_valid = 1'b0;
    check("idle_ready", {31'd0, ld_ready}, 32'd0);

    load_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    do_load(1'b0);
    fetch_chk(32'd4, 2);
    fetch_chk(32'd6, 2);
    fetch_chk(32'd8, 2);
    fetch_chk(32'd0, 2);

    load_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    do_load(1'b1);

    load_bytes.delete();
    for (int i = 0; i < 12; i++) load_bytes.push_back(8'(8'h30 + i));
    do_load(1'b1);

    for (int t = 0; t < 10; t++) begin
      load_bytes.delete();
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) load_bytes.push_back(8'($urandom));
      do_load(1'b1);
      n = ((n + 3) / 4 < MEM) ? (n + 3) / 4 : MEM;
      for (int k = 0; k < 3; k++) fetch_chk(32'($urandom_range(0, 4 * (n + 2))), n);
    end

    // Abort: reset in the middle of a load with gaps between bytes
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 2)) @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = 8'(8'hE0 + i);
      @(negedge clk);
      ld_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_ready", {31'd0, ld_ready}, 32'd0);
    check("abort_stall", {31'd0, fetch_stall}, 32'd1);
    check("abort_words", words_loaded, 32'd0);
    check("abort_load_done", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", {31'd0, ld_ready}, 32'd0);
    check("abort_no_pending", 32'(exp_q.size()), 32'd0);
    $display("abort done");

    load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
